// File: rtl/morse_pkg.sv
// ---------------------------------------------------------------------------
// morse_pkg
//   Shared definitions for the Morse receive path: 3-bit letter codes (same
//   codes as the Morse encoder), the decoder FSM state encoding and the
//   (length, symbols) -> letter lookup.
// ---------------------------------------------------------------------------
package morse_pkg;

  localparam logic [2:0] LTR_A = 3'b000;
  localparam logic [2:0] LTR_B = 3'b001;
  localparam logic [2:0] LTR_C = 3'b010;
  localparam logic [2:0] LTR_D = 3'b011;
  localparam logic [2:0] LTR_E = 3'b100;
  localparam logic [2:0] LTR_F = 3'b101;
  localparam logic [2:0] LTR_G = 3'b110;
  localparam logic [2:0] LTR_H = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_MARK  = 2'b01,
    ST_SPACE = 2'b10,
    ST_ABORT = 2'b11
  } morse_state_e;

  // Returns {hit, code}. Symbols enter at the LSB (1 = dash) and the buffer is
  // cleared at letter start, so unused upper bits are always zero.
  function automatic logic [3:0] morse_lookup(input logic [2:0] len, input logic [3:0] sym);
    logic [3:0] res;
    case ({len, sym})
      7'b001_0000: res = {1'b1, LTR_E};
      7'b010_0001: res = {1'b1, LTR_A};
      7'b011_0100: res = {1'b1, LTR_D};
      7'b011_0110: res = {1'b1, LTR_G};
      7'b100_1000: res = {1'b1, LTR_B};
      7'b100_1010: res = {1'b1, LTR_C};
      7'b100_0010: res = {1'b1, LTR_F};
      7'b100_0000: res = {1'b1, LTR_H};
      default:     res = {1'b0, LTR_A};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/morse_line_sync.sv
// ---------------------------------------------------------------------------
// morse_line_sync
//   Two-flop synchronizer bringing the asynchronous Morse line into the
//   ClockIn domain. Both flops clear on the asynchronous active-low Reset.
// Ports
//   ClockIn  in  1  system clock
//   Reset    in  1  asynchronous, active-low reset
//   line_i   in  1  raw serial line
//   line_o   out 1  synchronized line
// ---------------------------------------------------------------------------
module morse_line_sync (
  input  logic ClockIn,
  input  logic Reset,
  input  logic line_i,
  output logic line_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the raw line.
  always_ff @(posedge ClockIn or negedge Reset) begin
    if (!Reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
    end
  end

  assign line_o = sync_q;

endmodule

// File: rtl/morse_decoder.sv
// ---------------------------------------------------------------------------
// morse_decoder
//   Receive side of the Morse link. Measures mark/space run lengths in ClockIn
//   cycles, classifies marks as dot/dash, buffers up to 4 symbols and decodes
//   letters A..H when the inter-letter gap (2 units) is seen.
// Parameters
//   TICK_PERIOD  ClockIn cycles per Morse unit (>= 2)
// Ports
//   ClockIn      in  1  system clock
//   Reset        in  1  asynchronous, active-low reset
//   DotDashIn    in  1  serial Morse line (1 = mark), asynchronous
//   Letter       out 3  last successfully decoded letter code
//   LetterValid  out 1  1-cycle pulse, Letter updated in the same cycle
//   LetterError  out 1  1-cycle pulse, malformed letter discarded
//   Busy         out 1  high while a letter is being received
// ---------------------------------------------------------------------------
module morse_decoder
  import morse_pkg::*;
#(
  parameter int TICK_PERIOD = 250
) (
  input  logic       ClockIn,
  input  logic       Reset,
  input  logic       DotDashIn,
  output logic [2:0] Letter,
  output logic       LetterValid,
  output logic       LetterError,
  output logic       Busy
);

  localparam int CNT_MAX = 5 * TICK_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] MARK_LAST = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] GAP_LEN   = CNT_W'(2 * TICK_PERIOD);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(2 * TICK_PERIOD - 1);

  logic             line_s;
  morse_state_e     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [3:0]       sym_q;
  logic [2:0]       len_q;
  logic [2:0]       letter_q;
  logic             valid_q;
  logic             error_q;
  logic             busy_q;
  logic             dash_s;
  logic [3:0]       lookup_s;

  morse_line_sync u_sync (
    .ClockIn (ClockIn),
    .Reset   (Reset),
    .line_i  (DotDashIn),
    .line_o  (line_s)
  );

  // Saturating run-length increment, mark classification and letter lookup.
  always_comb begin
    cnt_d    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;
    dash_s   = (cnt_q >= GAP_LEN);
    lookup_s = morse_lookup(len_q, sym_q);
  end

  // Receive FSM with run counter, symbol buffer and registered outputs.
  always_ff @(posedge ClockIn or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= CNT_ZERO;
      sym_q    <= 4'b0000;
      len_q    <= 3'd0;
      letter_q <= LTR_A;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (line_s) begin
            state_q <= ST_MARK;
            cnt_q   <= CNT_ONE;
            sym_q   <= 4'b0000;
            len_q   <= 3'd0;
            busy_q  <= 1'b1;
          end
        end
        ST_MARK: begin
          if (line_s) begin
            // Mark reaching 5 units is a stuck line, not a symbol.
            if (cnt_q == MARK_LAST) begin
              error_q <= 1'b1;
              state_q <= ST_ABORT;
              cnt_q   <= CNT_ZERO;
            end else begin
              cnt_q <= cnt_d;
            end
          end else if (len_q == 3'd4) begin
            error_q <= 1'b1;
            state_q <= ST_ABORT;
            cnt_q   <= CNT_ZERO;
          end else begin
            sym_q   <= {sym_q[2:0], dash_s};
            len_q   <= len_q + 3'd1;
            state_q <= ST_SPACE;
            cnt_q   <= CNT_ONE;
          end
        end
        ST_SPACE: begin
          // Gap timeout is checked before the line so it wins over a new mark.
          if (cnt_q == GAP_LEN) begin
            if (lookup_s[3]) begin
              letter_q <= lookup_s[2:0];
              valid_q  <= 1'b1;
            end else begin
              error_q <= 1'b1;
            end
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            busy_q  <= 1'b0;
          end else if (line_s) begin
            state_q <= ST_MARK;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_ABORT: begin
          // Wait for an unbroken 2-unit low before accepting a new letter.
          if (line_s) begin
            cnt_q <= CNT_ZERO;
          end else if (cnt_q == GAP_LAST) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= CNT_ZERO;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Letter      = letter_q;
  assign LetterValid = valid_q;
  assign LetterError = error_q;
  assign Busy        = busy_q;

endmodule

// File: tb/tb_morse_decoder.sv
// ---------------------------------------------------------------------------
// tb_morse_decoder
//   Directed bench for morse_decoder with TICK_PERIOD = 4 (unit = 4 cycles).
//   Pulses are tallied by a negedge monitor; each scenario task compares the
//   tallies and outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_morse_decoder;

  logic       ClockIn;
  logic       Reset;
  logic       DotDashIn;
  logic [2:0] Letter;
  logic       LetterValid;
  logic       LetterError;
  logic       Busy;

  int checks;
  int errors;
  int valid_cnt;
  int error_cnt;
  int both_cnt;
  logic [2:0] valid_letter;

  morse_decoder #(.TICK_PERIOD(4)) dut (
    .ClockIn     (ClockIn),
    .Reset       (Reset),
    .DotDashIn   (DotDashIn),
    .Letter      (Letter),
    .LetterValid (LetterValid),
    .LetterError (LetterError),
    .Busy        (Busy)
  );

  initial ClockIn = 1'b0;
  always #5 ClockIn = ~ClockIn;

  // Pulse monitor, sampled away from the active edge.
  always @(negedge ClockIn) begin
    if (LetterValid) begin
      valid_cnt    = valid_cnt + 1;
      valid_letter = Letter;
    end
    if (LetterError) error_cnt = error_cnt + 1;
    if (LetterValid && LetterError) both_cnt = both_cnt + 1;
  end

  task automatic drive(input logic v, input int n);
    DotDashIn = v;
    repeat (n) @(posedge ClockIn);
    #1;
  endtask

  task automatic sym(input bit dash);
    drive(1'b1, dash ? 12 : 4);
    drive(1'b0, 4);
  endtask

  task automatic end_letter();
    drive(1'b0, 14);
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    DotDashIn = 1'b0;
    repeat (3) @(posedge ClockIn);
    #1;
    checks++; if (Letter !== 3'b000) begin errors++; $display("FAIL reset_letter got=%b exp=000", Letter); end
    checks++; if (LetterValid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", LetterValid); end
    checks++; if (LetterError !== 1'b0) begin errors++; $display("FAIL reset_error got=%b exp=0", LetterError); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    Reset = 1'b1;
    drive(1'b0, 2);
  endtask

  task automatic test_letter_a();
    int v0, e0;
    v0 = valid_cnt; e0 = error_cnt;
    drive(1'b1, 4); drive(1'b0, 4); drive(1'b1, 12); drive(1'b0, 8); drive(1'b0, 6);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL a_valid_count got=%0d exp=1", valid_cnt - v0); end
    checks++; if (valid_letter !== 3'b000) begin errors++; $display("FAIL a_letter got=%b exp=000", valid_letter); end
    checks++; if (error_cnt - e0 !== 0) begin errors++; $display("FAIL a_error_count got=%0d exp=0", error_cnt - e0); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL a_busy got=%b exp=0", Busy); end
  endtask

  task automatic test_h_then_e();
    int v0;
    v0 = valid_cnt;
    for (int i = 0; i < 4; i++) sym(1'b0);
    end_letter();
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL h_valid_count got=%0d exp=1", valid_cnt - v0); end
    checks++; if (Letter !== 3'b111) begin errors++; $display("FAIL h_letter got=%b exp=111", Letter); end
    sym(1'b0);
    end_letter();
    checks++; if (valid_cnt - v0 !== 2) begin errors++; $display("FAIL e_valid_count got=%0d exp=2", valid_cnt - v0); end
    checks++; if (Letter !== 3'b100) begin errors++; $display("FAIL e_letter got=%b exp=100", Letter); end
  endtask

  task automatic test_too_long();
    int v0, e0;
    v0 = valid_cnt; e0 = error_cnt;
    for (int i = 0; i < 4; i++) sym(1'b0);
    drive(1'b1, 4); drive(1'b0, 4);
    checks++; if (error_cnt - e0 !== 1) begin errors++; $display("FAIL five_dots_error got=%0d exp=1", error_cnt - e0); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL five_dots_valid got=%0d exp=0", valid_cnt - v0); end
    checks++; if (Letter !== 3'b100) begin errors++; $display("FAIL five_dots_hold got=%b exp=100", Letter); end
    drive(1'b0, 12);
    sym(1'b0); sym(1'b1); end_letter();
    checks++; if (Letter !== 3'b000) begin errors++; $display("FAIL after_abort_letter got=%b exp=000", Letter); end
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL after_abort_valid got=%0d exp=1", valid_cnt - v0); end
  endtask

  task automatic test_stuck_mark();
    int v0, e0;
    v0 = valid_cnt; e0 = error_cnt;
    drive(1'b1, 25);
    checks++; if (error_cnt - e0 !== 1) begin errors++; $display("FAIL stuck_error got=%0d exp=1", error_cnt - e0); end
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL stuck_busy_high got=%b exp=1", Busy); end
    drive(1'b0, 5);
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL abort_busy_early got=%b exp=1", Busy); end
    drive(1'b0, 8);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL abort_busy_done got=%b exp=0", Busy); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL stuck_valid got=%0d exp=0", valid_cnt - v0); end
    checks++; if (Letter !== 3'b000) begin errors++; $display("FAIL stuck_hold got=%b exp=000", Letter); end
  endtask

  task automatic test_unknown_letter();
    int v0, e0;
    sym(1'b1); sym(1'b0); sym(1'b0); end_letter();
    checks++; if (Letter !== 3'b011) begin errors++; $display("FAIL d_letter got=%b exp=011", Letter); end
    v0 = valid_cnt; e0 = error_cnt;
    sym(1'b1); sym(1'b1); sym(1'b1); end_letter();
    checks++; if (error_cnt - e0 !== 1) begin errors++; $display("FAIL o_error got=%0d exp=1", error_cnt - e0); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL o_valid got=%0d exp=0", valid_cnt - v0); end
    checks++; if (Letter !== 3'b011) begin errors++; $display("FAIL o_hold got=%b exp=011", Letter); end
  endtask

  task automatic test_reset_mid_letter();
    int v0, e0;
    sym(1'b1);
    drive(1'b1, 2);
    Reset = 1'b0;
    DotDashIn = 1'b0;
    #1;
    checks++; if (Letter !== 3'b000) begin errors++; $display("FAIL midreset_letter got=%b exp=000", Letter); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b exp=0", Busy); end
    checks++; if ({LetterValid, LetterError} !== 2'b00) begin errors++; $display("FAIL midreset_pulses got=%b exp=00", {LetterValid, LetterError}); end
    v0 = valid_cnt; e0 = error_cnt;
    @(posedge ClockIn); #1;
    Reset = 1'b1;
    drive(1'b0, 14);
    checks++; if (valid_cnt - v0 + error_cnt - e0 !== 0) begin errors++; $display("FAIL midreset_no_pulse got=%0d exp=0", valid_cnt - v0 + error_cnt - e0); end
    sym(1'b1); sym(1'b1); sym(1'b0); end_letter();
    checks++; if (Letter !== 3'b110) begin errors++; $display("FAIL g_letter got=%b exp=110", Letter); end
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL g_valid got=%0d exp=1", valid_cnt - v0); end
  endtask

  task automatic test_boundaries();
    int v0, e0;
    // Mark of exactly 2 units is a dash.
    drive(1'b1, 4); drive(1'b0, 4); drive(1'b1, 8); drive(1'b0, 4); end_letter();
    checks++; if (Letter !== 3'b000) begin errors++; $display("FAIL dash_exact got=%b exp=000", Letter); end
    // Mark one cycle short of 2 units is a dot.
    drive(1'b1, 7); drive(1'b0, 4); end_letter();
    checks++; if (Letter !== 3'b100) begin errors++; $display("FAIL dot_max got=%b exp=100", Letter); end
    // Gap one cycle short of 2 units stays inside the letter.
    v0 = valid_cnt; e0 = error_cnt;
    drive(1'b1, 4); drive(1'b0, 7); drive(1'b1, 8); drive(1'b0, 4); end_letter();
    checks++; if (Letter !== 3'b000) begin errors++; $display("FAIL gap_short_letter got=%b exp=000", Letter); end
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL gap_short_valid got=%0d exp=1", valid_cnt - v0); end
    // Timeout coinciding with a rising line: decode E, then a new (shortened) dot = E.
    v0 = valid_cnt; e0 = error_cnt;
    drive(1'b1, 4); drive(1'b0, 8); drive(1'b1, 4); drive(1'b0, 4); end_letter();
    checks++; if (valid_cnt - v0 !== 2) begin errors++; $display("FAIL timeout_race_valid got=%0d exp=2", valid_cnt - v0); end
    checks++; if (error_cnt - e0 !== 0) begin errors++; $display("FAIL timeout_race_error got=%0d exp=0", error_cnt - e0); end
    checks++; if (Letter !== 3'b100) begin errors++; $display("FAIL timeout_race_letter got=%b exp=100", Letter); end
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL exclusive got=%0d exp=0", both_cnt); end
  endtask

  initial begin
    checks = 0; errors = 0;
    valid_cnt = 0; error_cnt = 0; both_cnt = 0;
    valid_letter = 3'b000;
    Reset = 1'b0;
    DotDashIn = 1'b0;
    #1;
    test_reset();
    test_letter_a();
    test_h_then_e();
    test_too_long();
    test_stuck_mark();
    test_unknown_letter();
    test_reset_mid_letter();
    test_boundaries();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
